// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// datapath select codes and the packed control-word type.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_A      = 2'b11;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam int unsigned TIMER_W = 8;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctl_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// IR/ALU-flag/memory-handshake inputs and datapath control outputs of the
// multicycle controller; master = controller side.
interface multicycle_control_if #(parameter int unsigned STATE_W = 4);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic               alu_src_a;
  logic               instr_done;
  logic               illegal;
  logic               mem_err;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a,
           instr_done, illegal, mem_err, reg_dst, mem_to_reg, alu_src_b,
           alu_op, pc_src, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a,
           instr_done, illegal, mem_err, reg_dst, mem_to_reg, alu_src_b,
           alu_op, pc_src, state
  );
endinterface

// File: rtl/mc_mem_timer.sv
// Counts consecutive mem_ready-low cycles of one memory access; expired
// flags that MEM_TIMEOUT wait cycles have elapsed.
module mc_mem_timer
  import mips_mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic waiting,
  output logic expired
);

  logic [TIMER_W-1:0] cnt;

  assign expired = (cnt == TIMER_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (waiting && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with bounded memory waits.
// Optional jal/jr support: define MULTICYCLE_JAL_EN.
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned STATE_W     = 4
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t state, next;
  ctl_t   ctl, outs;
  logic   expired, waiting, clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  // Every taken transition (including the FETCH self-loop after a timeout)
  // restarts the wait count for the next access.
  assign waiting = is_mem_state(state) && !bus.mem_ready;
  assign clr     = (next != state) || expired;

  mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .waiting (waiting),
    .expired (expired)
  );

  always_comb begin
    ctl  = '0;
    next = state;
    case (state)
      S_FETCH: begin
        if (expired) begin
          ctl.mem_err = 1'b1;
        end else begin
          ctl.mem_read = 1'b1;
          if (bus.mem_ready) begin
            ctl.ir_write  = 1'b1;
            ctl.pc_en     = 1'b1;
            ctl.alu_src_b = SRCB_FOUR;
            next          = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMMSH;
        case (bus.opcode)
          OP_LW, OP_SW:             next = S_MEMADR;
          OP_BEQ, OP_BNE:           next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: next = S_IEX;
          OP_J:                     next = S_JUMP;
`ifdef MULTICYCLE_JAL_EN
          OP_RTYPE:                 next = (bus.funct == FN_JR) ? S_JR : S_REX;
          OP_JAL:                   next = S_JAL;
`else
          OP_RTYPE:                 next = S_REX;
`endif
          default: begin
            ctl.illegal = 1'b1;
            next        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        next          = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctl.iord = 1'b1;
        if (expired) begin
          ctl.mem_err = 1'b1;
          next        = S_FETCH;
        end else begin
          ctl.mem_read = 1'b1;
          if (bus.mem_ready) next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = M2R_MDR;
        ctl.reg_dst    = RD_RT;
        ctl.instr_done = 1'b1;
        next           = S_FETCH;
      end
      S_MEMWR: begin
        ctl.iord = 1'b1;
        if (expired) begin
          ctl.mem_err = 1'b1;
          next        = S_FETCH;
        end else begin
          ctl.mem_write = 1'b1;
          if (bus.mem_ready) begin
            ctl.instr_done = 1'b1;
            next           = S_FETCH;
          end
        end
      end
      S_REX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALU_FUNCT;
        next          = S_RWB;
      end
      S_RWB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = RD_RD;
        ctl.mem_to_reg = M2R_ALUOUT;
        ctl.instr_done = 1'b1;
        next           = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_op     = ALU_SUB;
        ctl.pc_src     = PC_ALUOUT;
        ctl.pc_en      = (bus.opcode == OP_BNE) ? !bus.zero : bus.zero;
        ctl.instr_done = 1'b1;
        next           = S_FETCH;
      end
      S_IEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = (bus.opcode == OP_ADDI) ? ALU_ADD : ALU_LOGIC;
        next          = S_IWB;
      end
      S_IWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        next           = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_src     = PC_JUMP;
        ctl.pc_en      = 1'b1;
        ctl.instr_done = 1'b1;
        next           = S_FETCH;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = RD_R31;
        ctl.mem_to_reg = M2R_PC;
        ctl.pc_src     = PC_JUMP;
        ctl.pc_en      = 1'b1;
        ctl.instr_done = 1'b1;
        next           = S_FETCH;
      end
      S_JR: begin
        ctl.pc_src     = PC_A;
        ctl.pc_en      = 1'b1;
        ctl.instr_done = 1'b1;
        next           = S_FETCH;
      end
`endif
      default: next = S_FETCH;
    endcase
  end

  // Outputs are forced low for as long as reset is held, not just after an edge.
  assign outs = reset ? '0 : ctl;

  assign bus.pc_en      = outs.pc_en;
  assign bus.iord       = outs.iord;
  assign bus.mem_read   = outs.mem_read;
  assign bus.mem_write  = outs.mem_write;
  assign bus.ir_write   = outs.ir_write;
  assign bus.reg_write  = outs.reg_write;
  assign bus.alu_src_a  = outs.alu_src_a;
  assign bus.instr_done = outs.instr_done;
  assign bus.illegal    = outs.illegal;
  assign bus.mem_err    = outs.mem_err;
  assign bus.reg_dst    = outs.reg_dst;
  assign bus.mem_to_reg = outs.mem_to_reg;
  assign bus.alu_src_b  = outs.alu_src_b;
  assign bus.alu_op     = outs.alu_op;
  assign bus.pc_src     = outs.pc_src;
  assign bus.state      = reset ? '0 : STATE_W'(state);

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of wait cycles with mem_ready low per memory access; legal range 1..255.
REQ-002 SHALL have parameter STATE_W, default 4, meaning the width of the state output.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have inputs opcode[5:0], funct[5:0] from the IR, zero (ALU flag) and mem_ready (memory handshake).
REQ-006 SHALL have 1-bit outputs pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, instr_done, illegal and mem_err.
REQ-007 SHALL have outputs reg_dst[1:0] (00 rt, 01 rd, 10 r31), mem_to_reg[1:0] (00 ALUOut, 01 MDR, 10 PC) and alu_src_b[1:0] (00 B, 01 const 4, 10 imm, 11 imm<<2).
REQ-008 SHALL have outputs alu_op[1:0] (00 add, 01 sub, 10 funct, 11 logical-imm), pc_src[1:0] (00 ALU, 01 ALUOut, 10 jump target, 11 A) and state[STATE_W-1:0].

Function
REQ-009 SHALL implement the states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BRANCH=8, IEX=9, IWB=10, JUMP=11, JAL=12 and JR=13.
REQ-010 SHALL make the transitions FETCH->DECODE (on ready) and DECODE->{lw/sw:MEMADR, R:REX, beq/bne:BRANCH, addi/andi/ori:IEX, j:JUMP}.
REQ-011 SHALL make the transitions MEMADR->MEMRD(lw)/MEMWR(sw), MEMRD->MEMWB (on ready), REX->RWB and IEX->IWB.
REQ-012 SHALL make MEMWB, MEMWR (on ready), RWB, IWB, BRANCH, JUMP, JAL and JR transition to FETCH.
REQ-013 SHALL treat FETCH, MEMRD and MEMWR as memory states: mem_read (FETCH, MEMRD) or mem_write (MEMWR) SHALL be held high with iord stable until mem_ready is sampled high.
REQ-014 SHALL, in FETCH, assert ir_write and pc_en (pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=00) only in the cycle mem_ready=1 (Mealy).
REQ-015 SHALL set alu_src_a=0, alu_src_b=11 and alu_op=00 in DECODE (branch target precompute).
REQ-016 SHALL, in BRANCH, drive alu_op=01 and pc_src=01, with pc_en=zero for beq and pc_en=~zero for bne.
REQ-017 SHALL, in JUMP, drive pc_src=10 and pc_en=1.
REQ-018 SHALL, in IEX, drive alu_op=00 for addi and 11 for andi/ori, with alu_src_b=10.
REQ-019 SHALL assert reg_write for one cycle in MEMWB (mem_to_reg=01, reg_dst=00), RWB (00/01) and IWB (00/00).
REQ-020 SHALL pulse instr_done for one cycle on every transition into FETCH, except on error.
REQ-021 SHALL, in DECODE with an undefined opcode, pulse illegal for one cycle, go to FETCH and assert no reg_write or pc_en.
REQ-022 SHALL count consecutive mem_ready-low cycles in each memory state; the counter clears on state entry.
REQ-023 SHALL, when the count reaches MEM_TIMEOUT, pulse mem_err for one cycle, drop the memory strobe and go to FETCH without pc_en or ir_write; PC SHALL NOT advance.
REQ-024 SHALL deassert all unlisted strobes (0) and leave all unlisted selects at 00 in every state.

Reset
REQ-025 SHALL, while reset=1, force state=FETCH, clear the wait counter and drive every output 0, independently of clk.
REQ-026 SHALL, in the first cycle after reset release, assert mem_read=1, iord=0 (FETCH).
REQ-027 SHALL, on reset mid-instruction, abandon the instruction with no reg_write or mem_write pulse afterwards.

Configuration
REQ-028 SHALL, with macro MULTICYCLE_JAL_EN defined, decode jal (opcode 000011) DECODE->JAL.
REQ-029 SHALL, in JAL, drive reg_write=1, reg_dst=10, mem_to_reg=10, pc_src=10 and pc_en=1.
REQ-030 SHALL, with MULTICYCLE_JAL_EN defined, decode R-type funct 001000 (jr) DECODE->JR; JR SHALL drive pc_src=11, pc_en=1 and reg_write=0.
REQ-031 SHALL, without MULTICYCLE_JAL_EN, treat opcode 000011 as illegal, treat jr as a plain R-type, and make states 12/13 unreachable.

Structure
REQ-032 SHALL place the opcode/funct constants, the state encoding, and the alu_op, pc_src, reg_dst and mem_to_reg encodings in shared package mips_mc_pkg.
REQ-033 SHALL implement the wait counter and timeout compare as sub-module mc_mem_timer (inputs clk, reset, clr, wait; output expired).

Verification
REQ-034 SHALL cover: mem_ready tied 1, lw -> states 0,1,2,3,4 over 5 cycles, reg_write=1 only in cycle 5, mem_to_reg=01, one instr_done.
REQ-035 SHALL cover: beq with zero=1, then bne with zero=1 -> pc_en=1 in BRANCH for beq, pc_en=0 for bne; each instruction takes 3 cycles.
REQ-036 SHALL cover: MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> mem_read high 4 cycles, then mem_err pulse, pc_en never high, state back to 0.
REQ-037 SHALL cover: sw with mem_ready low 2 cycles then high -> mem_write high 3 cycles in MEMWR, then FETCH, instr_done=1.
REQ-038 SHALL cover: opcode 111111 -> illegal pulse in DECODE, no reg_write; the second case asserts reset in REX -> state=0 immediately, all outputs 0.
REQ-039 SHALL cover: MULTICYCLE_JAL_EN builds, jal -> JAL with reg_dst=10, mem_to_reg=10, pc_en=1; without the macro, same opcode -> illegal.
